// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/stall controller (slave).
// state is a read-only debug view of the controller FSM (0 = RUN, 1 = LOAD_STALL, 2 = BUSY).
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  idex_memread;
    logic [REG_ADDR_W-1:0] idex_rt;
    logic                  muldiv_ex;
    logic                  branch_taken;
    logic                  exmem_regwrite;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  memwb_regwrite;
    logic [REG_ADDR_W-1:0] memwb_rd;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_write;
    logic                  idex_bubble;
    logic                  exmem_bubble;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic [CNT_W-1:0]      stall_cycles;
    logic [1:0]            state;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, idex_memread, idex_rt,
               muldiv_ex, branch_taken, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
               forward_a, forward_b, stall_cycles, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, idex_memread, idex_rt,
               muldiv_ex, branch_taken, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
               forward_a, forward_b, stall_cycles, state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: load-use stall, mult/div front-end hold,
// taken-branch flush, EX operand forwarding selects and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W    = 5,
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input logic               clock,
    input logic               reset_n,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BUSY       = 2'd2
    } state_t;

    localparam int MD_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [MD_W-1:0]       MD_LOAD  = MD_W'(MULDIV_CYCLES - 2);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    state_t           state_q, state_d;
    logic [MD_W-1:0]  mdcnt_q, mdcnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             lu;
    logic             pc_write_c;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  em_we,
        input logic [REG_ADDR_W-1:0] em_rd,
        input logic                  mw_we,
        input logic [REG_ADDR_W-1:0] mw_rd
    );
        if (em_we && em_rd != ZERO_REG && em_rd == src)      return 2'b10;
        else if (mw_we && mw_rd != ZERO_REG && mw_rd == src) return 2'b01;
        else                                                 return 2'b00;
    endfunction

    assign lu = bus.idex_memread && (bus.idex_rt != ZERO_REG) &&
                ((bus.idex_rt == bus.id_rs) || (bus.id_uses_rt && bus.idex_rt == bus.id_rt));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            mdcnt_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mdcnt_q <= mdcnt_d;
            if (!pc_write_c && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d          = state_q;
        mdcnt_d          = mdcnt_q;
        pc_write_c       = 1'b1;
        bus.ifid_write   = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_write   = 1'b1;
        bus.idex_bubble  = 1'b0;
        bus.exmem_bubble = 1'b0;
        case (state_q)
            RUN, LOAD_STALL: begin
                state_d = RUN;
                if (bus.branch_taken) begin
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                end else if (bus.muldiv_ex) begin
                    pc_write_c       = 1'b0;
                    bus.ifid_write   = 1'b0;
                    bus.idex_write   = 1'b0;
                    bus.exmem_bubble = 1'b1;
                    mdcnt_d          = MD_LOAD;
                    state_d          = BUSY;
                end else if (lu && state_q == RUN) begin
                    // One bubble per load; the value then comes back via MEM/WB forwarding.
                    pc_write_c      = 1'b0;
                    bus.ifid_write  = 1'b0;
                    bus.idex_bubble = 1'b1;
                    state_d         = LOAD_STALL;
                end
            end
            BUSY: begin
                if (mdcnt_q != '0) begin
                    pc_write_c       = 1'b0;
                    bus.ifid_write   = 1'b0;
                    bus.idex_write   = 1'b0;
                    bus.exmem_bubble = 1'b1;
                    mdcnt_d          = mdcnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // Outputs sit at their pass-through defaults for as long as reset is held.
        if (!reset_n) begin
            pc_write_c       = 1'b1;
            bus.ifid_write   = 1'b1;
            bus.ifid_flush   = 1'b0;
            bus.idex_write   = 1'b1;
            bus.idex_bubble  = 1'b0;
            bus.exmem_bubble = 1'b0;
        end
    end

    always_comb begin
        bus.forward_a = 2'b00;
        bus.forward_b = 2'b00;
        if (reset_n) begin
            bus.forward_a = fwd_sel(bus.ex_rs, bus.exmem_regwrite, bus.exmem_rd,
                                    bus.memwb_regwrite, bus.memwb_rd);
            bus.forward_b = fwd_sel(bus.ex_rt, bus.exmem_regwrite, bus.exmem_rd,
                                    bus.memwb_regwrite, bus.memwb_rd);
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.stall_cycles = cnt_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table for single-cycle behaviour plus
// hand-written mult/div, reset and counter-saturation sequences.
module tb_hazard_stall_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
    hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  bus2 ();

    hazard_stall_ctrl #(.REG_ADDR_W(5), .MULDIV_CYCLES(4), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
    hazard_stall_ctrl #(.REG_ADDR_W(5), .MULDIV_CYCLES(2), .CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2));

    always #5 clock = ~clock;

    // ctrl packs {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble}
    localparam logic [5:0] C_RUN   = 6'b110100;
    localparam logic [5:0] C_LOAD  = 6'b000110;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_HOLD  = 6'b000001;
    localparam logic [1:0] S_RUN = 2'd0, S_LS = 2'd1, S_BUSY = 2'd2;

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       uses_rt;
        logic [4:0] ex_rs, ex_rt;
        logic       memread;
        logic [4:0] idex_rt;
        logic       muldiv, branch;
        logic       em_we;
        logic [4:0] em_rd;
        logic       mw_we;
        logic [4:0] mw_rd;
        logic [5:0] ctrl;
        logic [1:0] fa, fb, st;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(
        input logic [4:0] id_rs, id_rt, input logic uses_rt,
        input logic [4:0] ex_rs, ex_rt, input logic memread, input logic [4:0] idex_rt,
        input logic muldiv, branch, input logic em_we, input logic [4:0] em_rd,
        input logic mw_we, input logic [4:0] mw_rd,
        input logic [5:0] ctrl, input logic [1:0] fa, fb, st);
        vec_t v;
        v.id_rs = id_rs; v.id_rt = id_rt; v.uses_rt = uses_rt;
        v.ex_rs = ex_rs; v.ex_rt = ex_rt; v.memread = memread; v.idex_rt = idex_rt;
        v.muldiv = muldiv; v.branch = branch;
        v.em_we = em_we; v.em_rd = em_rd; v.mw_we = mw_we; v.mw_rd = mw_rd;
        v.ctrl = ctrl; v.fa = fa; v.fb = fb; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_rs = v.id_rs; bus.id_rt = v.id_rt; bus.id_uses_rt = v.uses_rt;
        bus.ex_rs = v.ex_rs; bus.ex_rt = v.ex_rt;
        bus.idex_memread = v.memread; bus.idex_rt = v.idex_rt;
        bus.muldiv_ex = v.muldiv; bus.branch_taken = v.branch;
        bus.exmem_regwrite = v.em_we; bus.exmem_rd = v.em_rd;
        bus.memwb_regwrite = v.mw_we; bus.memwb_rd = v.mw_rd;
    endtask

    function automatic logic [5:0] ctrl_of();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_write, bus.idex_bubble, bus.exmem_bubble};
    endfunction

    function automatic logic [5:0] ctrl2_of();
        return {bus2.pc_write, bus2.ifid_write, bus2.ifid_flush,
                bus2.idex_write, bus2.idex_bubble, bus2.exmem_bubble};
    endfunction

    // Called at posedge+1: let combinational outputs settle, compare, then take the edge.
    task automatic cycle_check(input string name, input logic [5:0] exp_ctrl, input logic [1:0] exp_st);
        #3;
        check({name, " ctrl"}, 32'(ctrl_of()), 32'(exp_ctrl));
        if (exp_ctrl[5] == 1'b0) exp_cnt++;
        @(posedge clock);
        #1;
        check({name, " state"}, 32'(bus.state), 32'(exp_st));
    endtask

    vec_t idle;

    initial begin
        idle = mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, C_RUN, 2'b00, 2'b00, S_RUN);
        //        id_rs id_rt use ex_rs ex_rt mr idex_rt md br emwe emrd mwwe mwrd ctrl fa fb st
        vecs[0]  = mk(0,0,0,  0,0,  0,0,  0,0, 0,0, 0,0, C_RUN,   2'b00, 2'b00, S_RUN);
        vecs[1]  = mk(8,0,0,  0,0,  1,8,  0,0, 0,0, 0,0, C_LOAD,  2'b00, 2'b00, S_LS);
        vecs[2]  = mk(8,0,0,  0,0,  1,8,  0,0, 0,0, 0,0, C_RUN,   2'b00, 2'b00, S_RUN);
        vecs[3]  = mk(3,8,0,  0,0,  1,8,  0,0, 0,0, 0,0, C_RUN,   2'b00, 2'b00, S_RUN);
        vecs[4]  = mk(0,0,1,  0,0,  1,0,  0,0, 0,0, 0,0, C_RUN,   2'b00, 2'b00, S_RUN);
        vecs[5]  = mk(3,8,1,  0,0,  1,8,  0,0, 0,0, 0,0, C_LOAD,  2'b00, 2'b00, S_LS);
        vecs[6]  = mk(3,8,1,  0,0,  1,8,  0,1, 0,0, 0,0, C_FLUSH, 2'b00, 2'b00, S_RUN);
        vecs[7]  = mk(8,0,0,  0,0,  1,8,  0,1, 0,0, 0,0, C_FLUSH, 2'b00, 2'b00, S_RUN);
        vecs[8]  = mk(0,0,0,  5,5,  0,0,  0,0, 1,5, 1,5, C_RUN,   2'b10, 2'b10, S_RUN);
        vecs[9]  = mk(0,0,0,  5,6,  0,0,  0,0, 0,5, 1,5, C_RUN,   2'b01, 2'b00, S_RUN);
        vecs[10] = mk(0,0,0,  0,0,  0,0,  0,0, 1,0, 1,0, C_RUN,   2'b00, 2'b00, S_RUN);
        vecs[11] = mk(0,0,0,  9,7,  0,0,  0,0, 1,7, 1,9, C_RUN,   2'b01, 2'b10, S_RUN);
        vecs[12] = mk(0,0,0,  0,0,  0,0,  1,1, 0,0, 0,0, C_FLUSH, 2'b00, 2'b00, S_RUN);

        // Reset block: forwarding inputs match, yet outputs must stay at defaults.
        drive(idle);
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.ex_rs = 5'd5;
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.id_rs = 5'd8;
        bus2.id_rs = '0; bus2.id_rt = '0; bus2.id_uses_rt = 1'b0; bus2.ex_rs = '0; bus2.ex_rt = '0;
        bus2.idex_memread = 1'b0; bus2.idex_rt = '0; bus2.muldiv_ex = 1'b0; bus2.branch_taken = 1'b0;
        bus2.exmem_regwrite = 1'b0; bus2.exmem_rd = '0; bus2.memwb_regwrite = 1'b0; bus2.memwb_rd = '0;
        repeat (2) @(posedge clock);
        #4;
        check("reset ctrl", 32'(ctrl_of()), 32'(C_RUN));
        check("reset forward_a", 32'(bus.forward_a), 32'(2'b00));
        check("reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check("reset state", 32'(bus.state), 32'(S_RUN));
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("vec%0d ctrl", i), 32'(ctrl_of()), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d forward_a", i), 32'(bus.forward_a), 32'(vecs[i].fa));
            check($sformatf("vec%0d forward_b", i), 32'(bus.forward_b), 32'(vecs[i].fb));
            if (vecs[i].ctrl[5] == 1'b0) exp_cnt++;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d state", i), 32'(bus.state), 32'(vecs[i].st));
        end
        drive(idle);
        check("table stall_cycles", 32'(bus.stall_cycles), 32'(exp_cnt));

        // Mult/div held in EX for 4 cycles: three hold cycles then release; BUSY ignores branch.
        bus.muldiv_ex = 1'b1;
        cycle_check("md1", C_HOLD, S_BUSY);
        cycle_check("md2", C_HOLD, S_BUSY);
        bus.branch_taken = 1'b1;
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd4; bus.id_rs = 5'd4;
        cycle_check("md3", C_HOLD, S_BUSY);
        drive(idle);
        bus.muldiv_ex = 1'b1;
        cycle_check("md4", C_RUN, S_RUN);
        drive(idle);
        check("md stall_cycles", 32'(bus.stall_cycles), 32'(exp_cnt));

        // Asynchronous reset in BUSY cycle 2.
        bus.muldiv_ex = 1'b1;
        cycle_check("rst md1", C_HOLD, S_BUSY);
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.ex_rs = 5'd5;
        #1;
        check("pre-reset forward_a", 32'(bus.forward_a), 32'(2'b10));
        reset_n = 1'b0;
        #1;
        check("async reset ctrl", 32'(ctrl_of()), 32'(C_RUN));
        check("async reset forward_a", 32'(bus.forward_a), 32'(2'b00));
        check("async reset state", 32'(bus.state), 32'(S_RUN));
        check("async reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(idle);
        exp_cnt = 0;
        cycle_check("post reset", C_RUN, S_RUN);
        check("post reset stall_cycles", 32'(bus.stall_cycles), 32'd0);

        // MULDIV_CYCLES=2 instance: hold one cycle, release the next; 2-bit counter saturates.
        bus2.muldiv_ex = 1'b1;
        #3;
        check("md2c hold ctrl", 32'(ctrl2_of()), 32'(C_HOLD));
        @(posedge clock);
        #1;
        check("md2c hold state", 32'(bus2.state), 32'(S_BUSY));
        #3;
        check("md2c release ctrl", 32'(ctrl2_of()), 32'(C_RUN));
        @(posedge clock);
        #1;
        check("md2c release state", 32'(bus2.state), 32'(S_RUN));
        @(posedge clock);
        #1;
        check("sat count mid", 32'(bus2.stall_cycles), 32'd2);
        repeat (7) @(posedge clock);
        #1;
        check("sat count stuck", 32'(bus2.stall_cycles), 32'd3);
        bus2.muldiv_ex = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
